// File: rtl/csa_sum_sequencer.sv
// rtl/csa_sum_sequencer.sv - collects up to eight operands and emits their sum with a valid/ready handshake
// Optional feature: define CSA_SEQ_FLUSH_EN to add i_flush (early result of a partial collection).
module csa_sum_sequencer #(
    parameter int p_input_width = 14
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_valid,
    output logic                     o_ready,
    input  logic [p_input_width-1:0] i_data,
    output logic                     o_valid,
    input  logic                     i_ready,
    output logic [p_input_width+2:0] o_sum,
`ifdef CSA_SEQ_FLUSH_EN
    output logic [3:0]               o_count,
    input  logic                     i_flush
`else
    output logic [3:0]               o_count
`endif
);

    localparam logic STATE_COLLECT = 1'b0;
    localparam logic STATE_HOLD    = 1'b1;

    logic                     state_q, state_d;
    logic [p_input_width+2:0] acc_q, acc_d;
    logic [3:0]               cnt_q, cnt_d;
    logic                     valid_q, valid_d;
    logic [p_input_width+2:0] sum_q, sum_d;
    logic [3:0]               count_q, count_d;

    logic                     accept;
    logic [p_input_width+2:0] addend;
    logic [p_input_width+2:0] acc_sum;
    logic [3:0]               cnt_inc;
    logic                     full_close;
    logic                     flush_close;

    // Operands are only taken while collecting; reset blocks acceptance in the same cycle.
    assign o_ready = (state_q == STATE_COLLECT) && !i_rst;
    assign o_valid = valid_q;
    assign o_sum   = sum_q;
    assign o_count = count_q;

    // Next-state logic: accumulate in COLLECT, publish the result on the 8th operand (or a flush), release in HOLD.
    always_comb begin
        accept     = i_valid & o_ready;
        addend     = accept ? {3'b000, i_data} : '0;
        acc_sum    = acc_q + addend;
        cnt_inc    = cnt_q + {3'b000, accept};
        full_close = accept && (cnt_q == 4'd7);
`ifdef CSA_SEQ_FLUSH_EN
        flush_close = i_flush && ((cnt_q != 4'd0) || accept);
`else
        flush_close = 1'b0;
`endif

        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        sum_d   = sum_q;
        count_d = count_q;

        if (state_q == STATE_COLLECT) begin
            acc_d = acc_sum;
            cnt_d = cnt_inc;
            if (full_close || flush_close) begin
                // The result includes any operand accepted in this very cycle.
                state_d = STATE_HOLD;
                valid_d = 1'b1;
                sum_d   = acc_sum;
                count_d = cnt_inc;
            end
        end else begin
            // o_sum/o_count keep the last result after release until the next one is published.
            if (i_ready) begin
                state_d = STATE_COLLECT;
                valid_d = 1'b0;
                acc_d   = '0;
                cnt_d   = 4'd0;
            end
        end
    end

    // State registers; reset wins over any handshake, operand or flush in the same cycle.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= STATE_COLLECT;
            acc_q   <= '0;
            cnt_q   <= 4'd0;
            valid_q <= 1'b0;
            sum_q   <= '0;
            count_q <= 4'd0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            sum_q   <= sum_d;
            count_q <= count_d;
        end
    end

endmodule

// File: tb/tb_csa_sum_sequencer.sv
// tb/tb_csa_sum_sequencer.sv - self-checking bench for csa_sum_sequencer
module tb_csa_sum_sequencer;

    localparam int W = 14;

    logic           clk = 1'b0;
    logic           i_rst;
    logic           i_valid;
    logic           o_ready;
    logic [W-1:0]   i_data;
    logic           o_valid;
    logic           i_ready;
    logic [W+2:0]   o_sum;
    logic [3:0]     o_count;
`ifdef CSA_SEQ_FLUSH_EN
    logic           i_flush;
`endif

    int tests = 0;
    int fails = 0;

    typedef struct packed {
        logic [W+2:0] sum;
        logic [3:0]   cnt;
    } exp_t;

    exp_t sb_q[$];

    typedef struct {
        int base;
        int step;
        bit gap;
        int exp_sum;
    } vec_t;

    vec_t vecs[5];

    csa_sum_sequencer #(.p_input_width(W)) dut (
        .i_clk   (clk),
        .i_rst   (i_rst),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_data  (i_data),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_sum   (o_sum),
`ifdef CSA_SEQ_FLUSH_EN
        .o_count (o_count),
        .i_flush (i_flush)
`else
        .o_count (o_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input int sum, input int cnt);
        exp_t e;
        e.sum = (W+3)'(sum);
        e.cnt = 4'(cnt);
        sb_q.push_back(e);
    endtask

    task automatic send_ops(input int base, input int step, input bit gap);
        for (int i = 0; i < 8; i++) begin
            i_valid = 1'b1;
            i_data  = W'(base + step * i);
            cycle();
            if (gap) begin
                i_valid = 1'b0;
                i_data  = W'($urandom);
                cycle();
            end
        end
        i_valid = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 50 && sb_q.size() != 0; k++) cycle();
        check("drain_timeout", sb_q.size(), 0);
    endtask

    // Scoreboard: every handshake seen between edges must match the oldest expected result.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (!i_rst && o_valid && i_ready) begin
            if (sb_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_result: got sum %0d count %0d, expected no result", o_sum, o_count);
            end else begin
                e = sb_q.pop_front();
                check("result_sum", o_sum, e.sum);
                check("result_count", o_count, e.cnt);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{16383, 0,    1'b0, 131064};
        vecs[1] = '{0,     0,    1'b0, 0};
        vecs[2] = '{5,     0,    1'b1, 40};
        vecs[3] = '{100,   200,  1'b1, 6400};
        vecs[4] = '{7,     1000, 1'b0, 28056};

        i_rst = 1'b1; i_valid = 1'b0; i_data = '0; i_ready = 1'b1;
`ifdef CSA_SEQ_FLUSH_EN
        i_flush = 1'b0;
`endif
        cycle();
        cycle();
        check("rst_ready", o_ready, 0);
        check("rst_valid", o_valid, 0);
        check("rst_sum", o_sum, 0);
        check("rst_count", o_count, 0);
        i_rst = 1'b0;
        #1;
        check("post_rst_ready", o_ready, 1);

        // Operands 1..8 back-to-back: result one cycle after the 8th, released the next cycle.
        push_exp(36, 8);
        send_ops(1, 1, 1'b0);
        check("lat_valid", o_valid, 1);
        check("lat_sum", o_sum, 36);
        check("lat_count", o_count, 8);
        check("lat_ready", o_ready, 0);
        cycle();
        check("rel_valid", o_valid, 0);
        check("rel_ready", o_ready, 1);
        check("hold_sum_collect", o_sum, 36);
        check("hold_count_collect", o_count, 8);
        drain();

        for (int v = 0; v < 5; v++) begin
            push_exp(vecs[v].exp_sum, 8);
            send_ops(vecs[v].base, vecs[v].step, vecs[v].gap);
            drain();
        end

        // Downstream stalls for 5 cycles while upstream keeps offering data.
        i_ready = 1'b0;
        push_exp(24, 8);
        send_ops(3, 0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            i_valid = 1'b1;
            i_data  = W'(999);
            #1;
            check("stall_valid", o_valid, 1);
            check("stall_sum", o_sum, 24);
            check("stall_count", o_count, 8);
            check("stall_ready", o_ready, 0);
            cycle();
        end
        i_valid = 1'b0;
        i_ready = 1'b1;
        cycle();
        push_exp(8, 8);
        send_ops(1, 0, 1'b0);
        drain();

        // Reset discards a pending result.
        i_ready = 1'b0;
        send_ops(50, 0, 1'b0);
        i_rst = 1'b1;
        i_ready = 1'b1;
        #1;
        check("rst_pending_ready", o_ready, 0);
        cycle();
        i_rst = 1'b0;
        check("rst_pending_valid", o_valid, 0);
        check("rst_pending_sum", o_sum, 0);

        // Reset after four operands of 100 discards the partial sum.
        for (int i = 0; i < 4; i++) begin
            i_valid = 1'b1; i_data = W'(100); cycle();
        end
        i_valid = 1'b0;
        i_rst = 1'b1;
        cycle();
        i_rst = 1'b0;
        push_exp(8, 8);
        send_ops(1, 0, 1'b0);
        drain();

`ifdef CSA_SEQ_FLUSH_EN
        // Flush with a same-cycle operand, then a flush with nothing collected.
        i_valid = 1'b1; i_data = W'(10); cycle();
        i_data = W'(20); cycle();
        i_data = W'(30); i_flush = 1'b1;
        push_exp(60, 3);
        cycle();
        i_valid = 1'b0; i_flush = 1'b0;
        check("flush_valid", o_valid, 1);
        check("flush_count", o_count, 3);
        drain();
        i_flush = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cycle();
            check("empty_flush_valid", o_valid, 0);
        end
        i_flush = 1'b0;
`endif

        for (int k = 0; k < 5; k++) cycle();
        check("sb_empty", sb_q.size(), 0);
        check("final_valid", o_valid, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
